// File: rtl/sevenseg_scroller.sv
// Message buffer that loads ASCII characters over valid/ready, then scrolls a
// 4-character window (message + 4 trailing spaces) into a registered 128-bit vector.
module sevenseg_scroller #(
  parameter int DEPTH      = 16,
  parameter int SCROLL_DIV = 25000000
) (
  input  logic         system1000,
  input  logic         system1000_rst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [7:0]   wr_char,
  input  logic         wr_last,
  input  logic         enable,
  input  logic         reload,
  output logic [127:0] outputs_o,
  output logic         scrolling
);

  localparam int PW = $clog2(DEPTH + 4) + 1;
  localparam int DW = $clog2(SCROLL_DIV);
  localparam logic [127:0] ALL_SPACES = {4{32'd32}};

  typedef enum logic {ST_LOAD, ST_SCROLL} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  len_q, len_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic [DW-1:0]  div_q, div_d;
  logic [127:0]   out_q, out_d;
  logic [7:0]     msg_q [DEPTH];

  logic           wr_acc;
  logic [PW-1:0]  seq_len;
  logic [PW-1:0]  win_idx [4];
  logic [127:0]   window;

  assign wr_ready  = (state_q == ST_LOAD);
  assign scrolling = (state_q == ST_SCROLL);
  assign outputs_o = out_q;
  assign wr_acc    = wr_valid && wr_ready;
  assign seq_len   = len_q + PW'(4);

  // pos+k never reaches 2*seq_len, so one conditional subtract implements the modulo.
  always_comb begin
    window = ALL_SPACES;
    for (int k = 0; k < 4; k++) begin
      win_idx[k] = pos_q + PW'(k);
      if (win_idx[k] >= seq_len) begin
        win_idx[k] = win_idx[k] - seq_len;
      end
      if (win_idx[k] < len_q) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (win_idx[k] == PW'(j)) begin
            window[127-32*k -: 32] = {24'd0, msg_q[j]};
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    len_d   = len_q;
    pos_d   = pos_q;
    div_d   = div_q;
    out_d   = ALL_SPACES;
    case (state_q)
      ST_LOAD: begin
        if (wr_acc) begin
          wptr_d = wptr_q + 1'b1;
          if (wr_last || (wptr_q == PW'(DEPTH - 1))) begin
            len_d   = wptr_q + 1'b1;
            pos_d   = '0;
            div_d   = '0;
            state_d = ST_SCROLL;
          end
        end
      end
      ST_SCROLL: begin
        if (reload) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          len_d   = '0;
          div_d   = '0;
        end else begin
          out_d = window;
          if (enable) begin
            if (div_q == DW'(SCROLL_DIV - 1)) begin
              div_d = '0;
              pos_d = (pos_q == seq_len - PW'(1)) ? '0 : pos_q + 1'b1;
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q <= ST_LOAD;
      wptr_q  <= '0;
      len_q   <= '0;
      pos_q   <= '0;
      div_q   <= '0;
      out_q   <= ALL_SPACES;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      len_q   <= len_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
      out_q   <= out_d;
    end
  end

  // Buffer contents need no reset; only entries below len are ever displayed.
  always_ff @(posedge system1000) begin
    if (wr_acc) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (wptr_q == PW'(j)) begin
          msg_q[j] <= wr_char;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scroller.sv
// Directed bench for sevenseg_scroller with DEPTH=16, SCROLL_DIV=4.
module tb_sevenseg_scroller;

  logic         clk;
  logic         rst;
  logic         wr_valid;
  logic         wr_ready;
  logic [7:0]   wr_char;
  logic         wr_last;
  logic         enable;
  logic         reload;
  logic [127:0] outputs_o;
  logic         scrolling;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] SP4 = {4{32'd32}};

  sevenseg_scroller #(.DEPTH(16), .SCROLL_DIV(4)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_char        (wr_char),
    .wr_last        (wr_last),
    .enable         (enable),
    .reload         (reload),
    .outputs_o      (outputs_o),
    .scrolling      (scrolling)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] c, input logic l);
    wr_valid = 1'b1;
    wr_char  = c;
    wr_last  = l;
    tick();
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] w4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    return {24'd0, a, 24'd0, b, 24'd0, c, 24'd0, d};
  endfunction

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_char = 8'd0; wr_last = 1'b0;
    enable = 1'b1; reload = 1'b0;
    #2;
    chk("rst_out", outputs_o, SP4);
    chk("rst_ready", 128'(wr_ready), 128'd1);
    chk("rst_scroll", 128'(scrolling), 128'd0);
    #10 rst = 1'b0;
    tick();
    chk("load_idle_out", outputs_o, SP4);

    // "hello", valid held high through the whole load
    send("h", 1'b0); send("e", 1'b0); send("l", 1'b0); send("l", 1'b0); send("o", 1'b1);
    chk("hello_ready", 128'(wr_ready), 128'd0);
    chk("hello_scroll", 128'(scrolling), 128'd1);
    chk("hello_lag", outputs_o, SP4);
    wr_valid = 1'b0; wr_last = 1'b0;
    tick();  chk("hell", outputs_o, w4("h", "e", "l", "l"));
    ticks(3); chk("hell_hold", outputs_o, w4("h", "e", "l", "l"));
    tick();  chk("ello", outputs_o, w4("e", "l", "l", "o"));
    ticks(16); chk("pos5", outputs_o, SP4);
    ticks(12); chk("pos8", outputs_o, w4(8'd32, "h", "e", "l"));
    ticks(4);  chk("wrap", outputs_o, w4("h", "e", "l", "l"));

    // freeze with divider saved at 2
    tick();
    enable = 1'b0;
    ticks(20); chk("frozen", outputs_o, w4("h", "e", "l", "l"));
    enable = 1'b1;
    ticks(2); chk("reenable_hold", outputs_o, w4("h", "e", "l", "l"));
    tick();   chk("reenable_step", outputs_o, w4("e", "l", "l", "o"));

    // full buffer without wr_last; 17th character must be refused
    reload = 1'b1; tick(); reload = 1'b0;
    chk("reload_ready", 128'(wr_ready), 128'd1);
    chk("reload_scroll", 128'(scrolling), 128'd0);
    chk("reload_out", outputs_o, SP4);
    for (int i = 0; i < 16; i++) send(8'h41 + 8'(i), 1'b0);
    chk("full_scroll", 128'(scrolling), 128'd1);
    chk("full_ready", 128'(wr_ready), 128'd0);
    send(8'h51, 1'b0);
    chk("full_abcd", outputs_o, w4("A", "B", "C", "D"));
    wr_valid = 1'b0;
    ticks(52); chk("full_pos13", outputs_o, w4("N", "O", "P", 8'd32));
    ticks(24); chk("full_pos19", outputs_o, w4(8'd32, "A", "B", "C"));

    // reload on the same edge as a scheduled step
    ticks(2);
    reload = 1'b1; tick(); reload = 1'b0;
    chk("rl_step_ready", 128'(wr_ready), 128'd1);
    chk("rl_step_scroll", 128'(scrolling), 128'd0);
    chk("rl_step_out", outputs_o, SP4);
    send("w", 1'b0); send("o", 1'b0);
    wr_valid = 1'b0; reload = 1'b1; tick(); reload = 1'b0;
    chk("rl_in_load_ready", 128'(wr_ready), 128'd1);
    send("r", 1'b0); send("l", 1'b0); send("d", 1'b1);
    chk("world_scroll", 128'(scrolling), 128'd1);
    wr_valid = 1'b0; wr_last = 1'b0;
    tick();   chk("worl", outputs_o, w4("w", "o", "r", "l"));
    ticks(4); chk("orld", outputs_o, w4("o", "r", "l", "d"));

    // single-character message, L=5
    reload = 1'b1; tick(); reload = 1'b0;
    send("!", 1'b1);
    wr_valid = 1'b0; wr_last = 1'b0;
    tick();   chk("one_p0", outputs_o, w4("!", 8'd32, 8'd32, 8'd32));
    ticks(4); chk("one_p1", outputs_o, SP4);
    ticks(4); chk("one_p2", outputs_o, w4(8'd32, 8'd32, 8'd32, "!"));
    ticks(4); chk("one_p3", outputs_o, w4(8'd32, 8'd32, "!", 8'd32));
    ticks(4); chk("one_p4", outputs_o, w4(8'd32, "!", 8'd32, 8'd32));
    ticks(4); chk("one_wrap", outputs_o, w4("!", 8'd32, 8'd32, 8'd32));

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_out", outputs_o, SP4);
    chk("arst_ready", 128'(wr_ready), 128'd1);
    chk("arst_scroll", 128'(scrolling), 128'd0);
    tick();
    #2 rst = 1'b0;
    tick();
    chk("post_rst_out", outputs_o, SP4);
    send("a", 1'b0); send("b", 1'b1);
    wr_valid = 1'b0; wr_last = 1'b0;
    chk("post_rst_scroll", 128'(scrolling), 128'd1);
    tick(); chk("post_rst_ab", outputs_o, w4("a", "b", 8'd32, 8'd32));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
